cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller sitting directly upstream of the `sram` data array. It accepts one CPU request at a time, checks an internal tag/valid store, and serves read hits from `sram`. On a read miss it refills the line from the memory port. Writes are forwarded to memory and update `sram` only on a hit.

## Interface
- `WIDTH`, 64: data word width; must match `sram` `WIDTH`.
- `ASIZE`, 4: index bits; the cache holds 2^ASIZE one-word lines.
- `AW`, 16: word-address width for the CPU, memory, and `sram` address buses.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req_valid`  in  1  request offered.
- `cpu_req_ready`  out  1  controller can accept; high only in IDLE.
- `cpu_req_we`  in  1  1 = write, 0 = read.
- `cpu_req_addr`  in  AW  word address.
- `cpu_req_wdata`  in  WIDTH  write data.
- `cpu_resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `cpu_rdata`  out  WIDTH  read data; valid with `cpu_resp_valid` on reads.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts.
- `mem_req_we`  out  1  memory write.
- `mem_req_addr`  out  AW  memory word address.
- `mem_req_wdata`  out  WIDTH  memory write data.
- `mem_rvalid`  in  1  refill data valid.
- `mem_rdata`  in  WIDTH  refill data.
- `sram_we`, `sram_re`  out  1  to `sram` `we` / `re`.
- `sram_waddr`, `sram_raddr`  out  AW  to `sram`; index placed in bits [AW-1:AW-ASIZE], lower bits 0.
- `sram_d_write`  out  WIDTH  to `sram` `d_write`.
- `sram_d_read`  in  WIDTH  from `sram` `d_read` (combinational read).
- `hit_cnt`, `miss_cnt`  out  16  saturating read hit/miss counters.

## Operation
- Address split:
  - index = `cpu_req_addr[ASIZE-1:0]`
  - tag = `cpu_req_addr[AW-1:ASIZE]`, stored with a valid bit per line.
- Request capture: addr, we and wdata are registered on the accept cycle (`cpu_req_valid && cpu_req_ready`).
- IDLE:
  - `cpu_req_ready`=1.
  - On accept, go to LOOKUP.
- LOOKUP:
  - `sram_re`=1 and `sram_raddr` = index of the captured address.
  - hit = valid[index] && tag match.
  - Read hit: register `sram_d_read` into `cpu_rdata`, increment `hit_cnt`, go to RESP.
  - Read miss: increment `miss_cnt`, go to MEM_REQ.
  - Write hit: `sram_we`=1 with captured wdata this cycle; go to MEM_REQ.
  - Write miss: no `sram` or tag change; go to MEM_REQ.
- MEM_REQ:
  - `mem_req_valid`=1; addr, we and wdata are taken from the capture and held stable until `mem_req_ready`.
  - On handshake: a write goes to RESP, a read goes to MEM_WAIT.
- MEM_WAIT:
  - Wait for `mem_rvalid`.
  - In that cycle: `sram_we`=1, `sram_d_write`=`mem_rdata`, tag/valid[index] written, `cpu_rdata` <= `mem_rdata`; go to RESP.
- RESP: `cpu_resp_valid`=1 for one cycle, then return to IDLE.
- `mem_rvalid` outside MEM_WAIT is ignored.
- Counters saturate at 0xFFFF and do not wrap.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; `hit_cnt`=`miss_cnt`=0.
  - `cpu_req_ready`=1 once in IDLE.
  - All other outputs 0.
- Reset asserted mid-operation: return to IDLE immediately and drop `mem_req_valid`. The refill is abandoned: no `sram` write, no response.
- Read hit: accept at edge N, LOOKUP in cycle N+1, `cpu_resp_valid` in cycle N+2 (2-cycle latency).
- Read miss:
  - `mem_req_valid` from cycle N+2.
  - Handshake in cycle M, MEM_WAIT from M+1.
  - `mem_rvalid` in cycle K ≥ M+1 gives `cpu_resp_valid` in K+1.
- Write: `cpu_resp_valid` one cycle after the memory handshake. Write hits update `sram` in cycle N+1.
- Back-to-back: the next request is accepted no earlier than the cycle after RESP.
- Write to a line that is then read: the read hits and returns the new data, since the `sram` write completes at the end of LOOKUP.

## Structure
- Package `cache_pkg`:
  - state enum {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP}.
  - default WIDTH/ASIZE/AW constants.
  - index/tag extraction functions.
- Sub-module `cache_tag_array`:
  - 2^ASIZE tag+valid registers with asynchronous clear on `rst`.
  - one combinational lookup port and one write port.
- `sram` is instantiated by the parent alongside `cache_ctrl`, not inside it.

## Test plan
- Reset, then read addr 0x0013 → miss.
  - `mem_req_valid` with addr 0x0013, `mem_req_we`=0.
  - Memory returns 0xDEAD_BEEF_0000_0001 → `cpu_resp_valid` with that data.
  - `miss_cnt`=1.
- Re-read 0x0013 → hit: response 2 cycles after accept, no memory request, `hit_cnt`=1.
- Read 0x0023 (same index 3, different tag) → miss and refill.
  - A following read of 0x0013 misses again.
- Write hit 0x0023 data 0x55 → `sram_we` in LOOKUP; memory write issued; next read of 0x0023 returns 0x55 without a memory request.
- Write miss 0x0047 → memory write only; no `sram_we`; valid[7] stays 0.
- Hold `mem_req_ready` low 5 cycles → request fields stable.
  - Spurious `mem_rvalid` in MEM_REQ is ignored.
  - Assert `rst` during MEM_WAIT → no response and valid bits cleared.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the direct-mapped cache controller.
//   state_t      controller FSM states
//   CACHE_*      default data width, index bits and word-address width
//   addr_index / addr_tag  split a default-width word address into index and tag
package cache_pkg;

   localparam int CACHE_WIDTH = 64;
   localparam int CACHE_ASIZE = 4;
   localparam int CACHE_AW    = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_REQ,
      MEM_WAIT,
      RESP
   } state_t;

   function automatic logic [CACHE_ASIZE-1:0] addr_index(input logic [CACHE_AW-1:0] addr);
      return addr[CACHE_ASIZE-1:0];
   endfunction

   function automatic logic [CACHE_AW-CACHE_ASIZE-1:0] addr_tag(input logic [CACHE_AW-1:0] addr);
      return addr[CACHE_AW-1:CACHE_ASIZE];
   endfunction

endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: per-line tag + valid store for the direct-mapped cache.
//   clk, rst             clock, asynchronous active-high clear of all lines
//   rd_idx_i             combinational lookup index
//   rd_valid_o, rd_tag_o valid bit and tag of the looked-up line
//   wr_en_i, wr_idx_i,   write port: marks the line valid with wr_tag_i
//   wr_tag_i
module cache_tag_array #(
   parameter int ASIZE = 4,
   parameter int TAGW  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ASIZE-1:0] rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAGW-1:0]  rd_tag_o,
   input  logic             wr_en_i,
   input  logic [ASIZE-1:0] wr_idx_i,
   input  logic [TAGW-1:0]  wr_tag_i
);

   localparam int LINES = 1 << ASIZE;

   logic [LINES-1:0] valid_q;
   logic [TAGW-1:0]  tag_q [LINES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         tag_q[wr_idx_i]   <= wr_tag_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// placed in front of an external sram data array (combinational read).
//   cpu_req_*      single outstanding CPU request (ready only in IDLE)
//   cpu_resp_valid one-cycle completion pulse, cpu_rdata carries read data
//   mem_req_*      memory request (held stable until mem_req_ready)
//   mem_rvalid/rdata  refill data return
//   sram_*         data-array control; line index sits in the top ASIZE bits
//   hit_cnt, miss_cnt  saturating read hit/miss counters
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int WIDTH = CACHE_WIDTH,
   parameter int ASIZE = CACHE_ASIZE,
   parameter int AW    = CACHE_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req_valid,
   output logic             cpu_req_ready,
   input  logic             cpu_req_we,
   input  logic [AW-1:0]    cpu_req_addr,
   input  logic [WIDTH-1:0] cpu_req_wdata,
   output logic             cpu_resp_valid,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_we,
   output logic [AW-1:0]    mem_req_addr,
   output logic [WIDTH-1:0] mem_req_wdata,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             sram_we,
   output logic             sram_re,
   output logic [AW-1:0]    sram_waddr,
   output logic [AW-1:0]    sram_raddr,
   output logic [WIDTH-1:0] sram_d_write,
   input  logic [WIDTH-1:0] sram_d_read,
   output logic [15:0]      hit_cnt,
   output logic [15:0]      miss_cnt
);

   localparam int TAGW = AW - ASIZE;

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q;
   logic             we_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [15:0]      hit_q, hit_d, miss_q, miss_d;

   logic [ASIZE-1:0] idx;
   logic [TAGW-1:0]  tag;
   logic [AW-1:0]    line_addr;
   logic             tag_valid, hit, tag_we, accept;
   logic [TAGW-1:0]  tag_rd;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign idx       = addr_q[ASIZE-1:0];
   assign tag       = addr_q[AW-1:ASIZE];
   assign line_addr = {idx, {(AW-ASIZE){1'b0}}};
   assign hit       = tag_valid && (tag_rd == tag);
   assign accept    = cpu_req_valid && (state_q == IDLE);

   cache_tag_array #(.ASIZE(ASIZE), .TAGW(TAGW)) u_tags (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (idx),
      .rd_valid_o (tag_valid),
      .rd_tag_o   (tag_rd),
      .wr_en_i    (tag_we),
      .wr_idx_i   (idx),
      .wr_tag_i   (tag)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cpu_req_valid) state_d = LOOKUP;
         LOOKUP:   state_d = (!we_q && hit) ? RESP : MEM_REQ;
         MEM_REQ:  if (mem_req_ready) state_d = we_q ? RESP : MEM_WAIT;
         MEM_WAIT: if (mem_rvalid) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // output logic
   always_comb begin
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      sram_we        = 1'b0;
      sram_re        = 1'b0;
      sram_waddr     = '0;
      sram_raddr     = '0;
      sram_d_write   = '0;
      tag_we         = 1'b0;
      case (state_q)
         IDLE: cpu_req_ready = 1'b1;
         LOOKUP: begin
            sram_re    = 1'b1;
            sram_raddr = line_addr;
            // write-through: update the data array only if the line is resident
            if (we_q && hit) begin
               sram_we      = 1'b1;
               sram_waddr   = line_addr;
               sram_d_write = wdata_q;
            end
         end
         MEM_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_we    = we_q;
            mem_req_addr  = addr_q;
            mem_req_wdata = wdata_q;
         end
         MEM_WAIT: begin
            if (mem_rvalid) begin
               sram_we      = 1'b1;
               sram_waddr   = line_addr;
               sram_d_write = mem_rdata;
               tag_we       = 1'b1;
            end
         end
         RESP: cpu_resp_valid = 1'b1;
         default: ;
      endcase
   end

   // request capture; only consumed after accept, so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= cpu_req_addr;
         we_q    <= cpu_req_we;
         wdata_q <= cpu_req_wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      if (state_q == LOOKUP && !we_q) begin
         if (hit) begin
            rdata_d = sram_d_read;
            hit_d   = sat_inc(hit_q);
         end else begin
            miss_d = sat_inc(miss_q);
         end
      end
      if (state_q == MEM_WAIT && mem_rvalid) begin
         rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign hit_cnt   = hit_q;
   assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed-vector bench for cache_ctrl with a behavioural sram
// and a response scoreboard drained by an independent monitor.
module tb_cache_ctrl;
   import cache_pkg::*;

   localparam int W   = 64;
   localparam int AS  = 4;
   localparam int AWL = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [AWL-1:0] cpu_req_addr;
   logic [W-1:0]   cpu_req_wdata;
   logic           cpu_resp_valid;
   logic [W-1:0]   cpu_rdata;
   logic           mem_req_valid, mem_req_ready, mem_req_we;
   logic [AWL-1:0] mem_req_addr;
   logic [W-1:0]   mem_req_wdata;
   logic           mem_rvalid;
   logic [W-1:0]   mem_rdata;
   logic           sram_we, sram_re;
   logic [AWL-1:0] sram_waddr, sram_raddr;
   logic [W-1:0]   sram_d_write, sram_d_read;
   logic [15:0]    hit_cnt, miss_cnt;

   cache_ctrl #(.WIDTH(W), .ASIZE(AS), .AW(AWL)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_we     (cpu_req_we),
      .cpu_req_addr   (cpu_req_addr),
      .cpu_req_wdata  (cpu_req_wdata),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_rdata      (cpu_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .sram_we        (sram_we),
      .sram_re        (sram_re),
      .sram_waddr     (sram_waddr),
      .sram_raddr     (sram_raddr),
      .sram_d_write   (sram_d_write),
      .sram_d_read    (sram_d_read),
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt)
   );

   always #5 clk = ~clk;

   // behavioural data array: registered write, combinational read
   logic [W-1:0] sram_mem [1<<AS];
   always @(posedge clk) begin
      if (sram_we) sram_mem[sram_waddr[AWL-1:AWL-AS]] <= sram_d_write;
   end
   assign sram_d_read = sram_mem[sram_raddr[AWL-1:AWL-AS]];

   typedef struct packed {
      logic         is_rd;
      logic [W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_fail = 0;
   int   hits_exp = 0;
   int   miss_exp = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // monitor: every response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (cpu_resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", {63'd0, cpu_resp_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_rd) check("resp_rdata", cpu_rdata, mon_e.data);
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (cpu_req_ready !== 1'b1 && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("req_ready", {63'd0, cpu_req_ready}, 64'd1);
   endtask

   // one CPU transaction; timing checks follow the expected FSM path
   task automatic xact(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                       input logic exp_hit, input logic [63:0] mdata, input logic [63:0] exp_rd,
                       input int rdy_dly, input logic abort);
      logic [15:0] sa;
      sa = {addr_index(addr), 12'h000};
      wait_ready();
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      if (!abort) exp_q.push_back('{is_rd: !we, data: exp_rd});
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      cpu_req_wdata = '0;
      cpu_req_we    = 1'b0;
      @(negedge clk);
      check("lookup_re", sram_re, 1);
      check("lookup_raddr", sram_raddr, sa);
      check("lookup_sram_we", sram_we, we && exp_hit);
      if (we && exp_hit) check("lookup_dwrite", sram_d_write, wdata);
      if (!we) begin
         if (exp_hit) hits_exp++;
         else miss_exp++;
      end
      if (!we && exp_hit) begin
         @(negedge clk);
         check("hit_resp_latency", cpu_resp_valid, 1);
         check("hit_no_memreq", mem_req_valid, 0);
      end else begin
         @(negedge clk);
         check("memreq_valid", mem_req_valid, 1);
         check("memreq_addr", mem_req_addr, addr);
         check("memreq_we", mem_req_we, we);
         if (we) check("memreq_wdata", mem_req_wdata, wdata);
         for (int i = 0; i < rdy_dly; i++) begin
            if (i == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            @(negedge clk);
            check("hold_valid", mem_req_valid, 1);
            check("hold_addr", mem_req_addr, addr);
            check("hold_we", mem_req_we, we);
            if (we) check("hold_wdata", mem_req_wdata, wdata);
            check("hold_no_resp", cpu_resp_valid, 0);
         end
         mem_req_ready = 1'b1;
         @(posedge clk);
         #1;
         mem_req_ready = 1'b0;
         @(negedge clk);
         if (we) begin
            check("wr_resp_latency", cpu_resp_valid, 1);
         end else begin
            check("wait_no_resp", cpu_resp_valid, 0);
            check("wait_no_memreq", mem_req_valid, 0);
            mem_rvalid = 1'b1;
            mem_rdata  = mdata;
            if (abort) begin
               rst = 1'b1;
               #1;
               check("abort_memreq", mem_req_valid, 0);
               check("abort_sram_we", sram_we, 0);
               check("abort_ready", cpu_req_ready, 1);
               @(posedge clk);
               #1;
               mem_rvalid = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               hits_exp = 0;
               miss_exp = 0;
               check("abort_no_resp", cpu_resp_valid, 0);
            end else begin
               #1;
               check("refill_sram_we", sram_we, 1);
               check("refill_waddr", sram_waddr, sa);
               check("refill_dwrite", sram_d_write, mdata);
               @(posedge clk);
               #1;
               mem_rvalid = 1'b0;
               @(negedge clk);
               check("refill_resp_latency", cpu_resp_valid, 1);
            end
         end
      end
      @(posedge clk);
      #1;
      check("hit_cnt", hit_cnt, hits_exp);
      check("miss_cnt", miss_cnt, miss_exp);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      cpu_req_valid = 1'b0;
      cpu_req_we    = 1'b0;
      cpu_req_addr  = '0;
      cpu_req_wdata = '0;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      for (int i = 0; i < (1 << AS); i++) sram_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", cpu_req_ready, 1);
      check("rst_resp", cpu_resp_valid, 0);
      check("rst_memreq", mem_req_valid, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_sram_re", sram_re, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      //    we    addr      wdata   hit   mem data               expected rdata         rdy abort
      xact(1'b0, 16'h0013, 64'h0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);
      xact(1'b0, 16'h0013, 64'h0, 1'b1, 64'h0,                   64'hDEAD_BEEF_0000_0001, 0, 1'b0);
      xact(1'b0, 16'h0023, 64'h0, 1'b0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 2, 1'b0);
      xact(1'b0, 16'h0013, 64'h0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);
      xact(1'b0, 16'h0023, 64'h0, 1'b0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0, 1'b0);
      xact(1'b1, 16'h0023, 64'h55, 1'b1, 64'h0,                  64'h0,                   1, 1'b0);
      xact(1'b0, 16'h0023, 64'h0, 1'b1, 64'h0,                   64'h55,                  0, 1'b0);
      xact(1'b1, 16'h0047, 64'h77, 1'b0, 64'h0,                  64'h0,                   3, 1'b0);
      xact(1'b0, 16'h0047, 64'h0, 1'b0, 64'hABCD_0000_0000_0047, 64'hABCD_0000_0000_0047, 5, 1'b0);
      xact(1'b0, 16'h0013, 64'h0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0,                   0, 1'b1);
      xact(1'b0, 16'h0023, 64'h0, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b0);
      xact(1'b0, 16'h0047, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
